// File: rtl/rx_serial_8n1.sv
// Asynchronous serial receiver (8N1, or 8E1 when RX_SERIAL_PARIDADE_EN is defined).
// Recovers characters from a 2-flop synchronized line sampled at mid-bit.
module rx_serial_8n1 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int M        = CLK_FREQ / BAUD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       recebe,
    output logic [7:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_quadro,
    output logic       erro_paridade,
    output logic       db_tick,
    output logic [3:0] db_estado
);

    localparam int CW = ($clog2(M) > 9) ? $clog2(M) : 9;
    localparam logic [CW-1:0] HALF_CNT = CW'(M / 2);
    localparam logic [CW-1:0] BIT_CNT  = CW'(M - 1);

    // states: 0 idle, 1 start, 2 data, 5 parity, 3 stop, 4 store, 6 wait line idle
    localparam logic [3:0] INICIAL  = 4'd0;
    localparam logic [3:0] START    = 4'd1;
    localparam logic [3:0] DADOS    = 4'd2;
    localparam logic [3:0] STOP     = 4'd3;
    localparam logic [3:0] ARMAZENA = 4'd4;
    localparam logic [3:0] PARIDADE = 4'd5;
    localparam logic [3:0] ESPERA   = 4'd6;

    logic          sync1;
    logic          s;
    logic [3:0]    state;
    logic [3:0]    state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          store;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= dado_serial;
            s     <= sync1;
        end
    end

    always_comb begin
        tick = 1'b0;
        case (state)
            START:                 tick = (cnt == HALF_CNT);
            DADOS, PARIDADE, STOP: tick = (cnt == BIT_CNT);
            default:               tick = 1'b0;
        endcase
    end

    assign store = (state == STOP) && tick && s;

    always_comb begin
        state_next = state;
        case (state)
            INICIAL:  if (!s) state_next = START;
            START:    if (tick) state_next = s ? INICIAL : DADOS;
            DADOS: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef RX_SERIAL_PARIDADE_EN
                    state_next = PARIDADE;
`else
                    state_next = STOP;
`endif
                end
            end
            PARIDADE: if (tick) state_next = STOP;
            STOP:     if (tick) state_next = s ? ARMAZENA : ESPERA;
            ARMAZENA: state_next = INICIAL;
            ESPERA:   if (s) state_next = INICIAL;
            default:  state_next = INICIAL;
        endcase
    end

    // The counter restarts both on a state change and after every sample so
    // consecutive data bits stay exactly M cycles apart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= INICIAL;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            dados_ascii <= '0;
            pronto      <= 1'b0;
            tem_dado    <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= (tick || state_next != state) ? '0 : cnt + 1'b1;
            pronto      <= 1'b0;
            erro_quadro <= 1'b0;
            if (tick) begin
                case (state)
                    START: bit_idx <= '0;
                    DADOS: begin
                        shreg   <= {s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    STOP: begin
                        if (s) begin
                            dados_ascii <= shreg;
                            pronto      <= 1'b1;
                        end else begin
                            erro_quadro <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Setting through the store cycle means an ack there cannot lose the character.
            if (store || state == ARMAZENA) begin
                tem_dado <= 1'b1;
            end else if (recebe) begin
                tem_dado <= 1'b0;
            end
        end
    end

`ifdef RX_SERIAL_PARIDADE_EN
    logic par_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if (state == PARIDADE && tick) begin
            par_bad <= s ^ (^shreg);
        end
    end

    assign erro_paridade = (state == STOP) && tick && par_bad;
`else
    assign erro_paridade = 1'b0;
`endif

    assign db_tick   = tick;
    assign db_estado = state;

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Bench for rx_serial_8n1: frame-level reference model with per-cycle output compare,
// directed scenarios plus randomized frames and acknowledges.
module tb_rx_serial_8n1;

    localparam int M = 434;
`ifdef RX_SERIAL_PARIDADE_EN
    localparam int NB  = 11;
    localparam int LAT = 4561;
`else
    localparam int NB  = 10;
    localparam int LAT = 4127;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic       recebe = 1'b0;
    logic [7:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_quadro;
    logic       erro_paridade;
    logic       db_tick;
    logic [3:0] db_estado;

    rx_serial_8n1 dut (
        .clock        (clock),
        .reset        (reset),
        .dado_serial  (dado_serial),
        .recebe       (recebe),
        .dados_ascii  (dados_ascii),
        .pronto       (pronto),
        .tem_dado     (tem_dado),
        .erro_quadro  (erro_quadro),
        .erro_paridade(erro_paridade),
        .db_tick      (db_tick),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // model state shared between driver and compare process
    ev_t        evq[$];
    int         tk_base = 0;
    int         tk_cnt = 0;
    logic       rcv_rand = 1'b0;
    logic       rcv_force = 1'b0;

    logic       x_p, x_fe, x_pe, x_tick;
    logic       x_td = 1'b0;
    logic [7:0] x_data = 8'h00;
    logic       prev_p = 1'b0;
    logic       prev_rcv = 1'b0;
    int         n_pronto = 0;
    int         n_fe = 0;
    int         n_pe = 0;
    int         last_pronto_cyc = 0;

    initial forever begin
        @(posedge clock);
        #2;
        recebe = rcv_rand ? ($urandom_range(0, 15) == 0) : rcv_force;
    end

    always @(negedge clock) begin
        x_p = 1'b0; x_fe = 1'b0; x_pe = 1'b0; x_tick = 1'b0;
        if (reset) begin
            x_td   = 1'b0;
            x_data = 8'h00;
            prev_p = 1'b0;
        end else begin
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                x_p  = ~evq[0].fe;
                x_fe = evq[0].fe;
                if (x_p) x_data = evq[0].data;
                evq.delete(0);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc + 1) x_pe = evq[0].pe;
            x_td = x_p | prev_p | (x_td & ~prev_rcv);
            if (tk_cnt > 0 && cyc >= tk_base && (cyc - tk_base) % M == 0 &&
                (cyc - tk_base) / M < tk_cnt) x_tick = 1'b1;
            prev_p = x_p;
        end
        prev_rcv = recebe;
        chk("outputs", 32'({pronto, erro_quadro, erro_paridade, db_tick, tem_dado, dados_ascii}),
            32'({x_p, x_fe, x_pe, x_tick, x_td, x_data}));
        if (pronto) begin
            n_pronto++;
            last_pronto_cyc = cyc;
        end
        if (erro_quadro) n_fe++;
        if (erro_paridade) n_pe++;
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        evq.delete();
        tk_cnt = 0;
        dado_serial = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
    endtask

    // Drives one frame starting now; abort_at < 8 resets the DUT halfway through that data bit.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                              input int abort_at);
        int   n;
        ev_t  ev;
        logic par;
        par = (^b) ^ par_flip;
        dado_serial = 1'b0;
        n = cyc;
        tk_base = n + 220;
        tk_cnt  = NB;
        ev.cyc  = n + 221 + (NB - 1) * M;
        ev.data = b;
        ev.fe   = ~stop;
`ifdef RX_SERIAL_PARIDADE_EN
        ev.pe   = par_flip;
`else
        ev.pe   = 1'b0;
`endif
        if (abort_at > 7) evq.push_back(ev);
        wait_cycles(M);
        for (int k = 0; k < 8; k++) begin
            dado_serial = b[k];
            if (k == abort_at) begin
                wait_cycles(M / 2);
                do_reset();
                return;
            end
            wait_cycles(M);
        end
`ifdef RX_SERIAL_PARIDADE_EN
        dado_serial = par;
        wait_cycles(M);
`else
        if (par === 1'bx) dado_serial = 1'b1;
`endif
        dado_serial = stop;
        wait_cycles(M);
        dado_serial = 1'b1;
    endtask

    initial begin
        int         n0;
        int         base;
        int         base_pe;
        logic [7:0] rb;
        logic       flip;

        #1;
        wait_cycles(4);
        chk("reset_data", 32'(dados_ascii), 32'h00);
        chk("reset_state", 32'(db_estado), 32'h0);
        chk("reset_flags", 32'({pronto, tem_dado, erro_quadro, erro_paridade, db_tick}), 32'h0);
        reset = 1'b0;
        wait_cycles(20);

        // single character, then acknowledge
        n0 = cyc;
        send_frame(8'hB5, 1'b0, 1'b1, 99);
        chk("t1_data", 32'(dados_ascii), 32'hB5);
        chk("t1_tem_dado", 32'(tem_dado), 32'h1);
        chk("t1_pronto_count", 32'(n_pronto), 32'd1);
        chk("t1_latency", 32'(last_pronto_cyc - n0), 32'(LAT));
        rcv_force = 1'b1;
        wait_cycles(1);
        rcv_force = 1'b0;
        wait_cycles(2);
        chk("t1_tem_dado_clr", 32'(tem_dado), 32'h0);

        // back-to-back, no acknowledge
        base = n_pronto;
        send_frame(8'hD5, 1'b0, 1'b1, 99);
        send_frame(8'hFE, 1'b0, 1'b1, 99);
        wait_cycles(5);
        chk("t2_pronto_count", 32'(n_pronto - base), 32'd2);
        chk("t2_data", 32'(dados_ascii), 32'hFE);
        chk("t2_tem_dado", 32'(tem_dado), 32'h1);
        chk("t2_no_frame_err", 32'(n_fe), 32'd0);

        // 100-cycle glitch
        base = n_pronto;
        dado_serial = 1'b0;
        tk_base = cyc + 220;
        tk_cnt  = 1;
        wait_cycles(50);
        chk("t3_in_start", 32'(db_estado), 32'd1);
        wait_cycles(50);
        dado_serial = 1'b1;
        wait_cycles(300);
        chk("t3_back_idle", 32'(db_estado), 32'd0);
        chk("t3_no_pronto", 32'(n_pronto - base), 32'd0);
        chk("t3_no_frame_err", 32'(n_fe), 32'd0);

        // stop bit low, line then held in break
        send_frame(8'hFF, 1'b0, 1'b0, 99);
        dado_serial = 1'b0;
        wait_cycles(M);
        chk("t4_espera", 32'(db_estado), 32'd6);
        wait_cycles(M);
        chk("t4_espera_hold", 32'(db_estado), 32'd6);
        dado_serial = 1'b1;
        wait_cycles(4);
        chk("t4_idle", 32'(db_estado), 32'd0);
        chk("t4_frame_err_count", 32'(n_fe), 32'd1);
        chk("t4_data_kept", 32'(dados_ascii), 32'hFE);

        // reset in the middle of a frame
        wait_cycles(10);
        send_frame(8'h35, 1'b0, 1'b1, 4);
        chk("t5_data_reset", 32'(dados_ascii), 32'h00);
        chk("t5_tem_dado_reset", 32'(tem_dado), 32'h0);
        chk("t5_state_reset", 32'(db_estado), 32'd0);
        wait_cycles(10);
        base = n_pronto;
        send_frame(8'h41, 1'b0, 1'b1, 99);
        chk("t5_pronto_count", 32'(n_pronto - base), 32'd1);
        chk("t5_data", 32'(dados_ascii), 32'h41);

`ifdef RX_SERIAL_PARIDADE_EN
        base_pe = n_pe;
        send_frame(8'h03, 1'b0, 1'b1, 99);
        chk("t6_par_ok", 32'(n_pe - base_pe), 32'd0);
        send_frame(8'h03, 1'b1, 1'b1, 99);
        chk("t6_par_bad", 32'(n_pe - base_pe), 32'd1);
        chk("t6_data", 32'(dados_ascii), 32'h03);
`else
        base_pe = n_pe;
`endif

        // randomized frames, gaps and acknowledges
        rcv_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cycles($urandom_range(0, 40));
            rb = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            send_frame(rb, flip, 1'b1, 99);
        end
        rcv_rand = 1'b0;
        wait_cycles(10);
        chk("pending_events", 32'(evq.size()), 32'd0);
`ifndef RX_SERIAL_PARIDADE_EN
        chk("no_parity_err", 32'(n_pe - base_pe), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_serial_8n1.md
# rx_serial_8n1

Asynchronous serial receiver that sits directly downstream of the team's serial transmitter. It samples the `saida_serial` line produced by the transmitter, or the external RX pin, on the system clock and recovers 8-bit characters. Each character is presented on `dados_ascii` with a one-cycle `pronto` strobe and a sticky `tem_dado` flag, which the consumer clears through the `recebe` handshake.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `M`, CLK_FREQ/BAUD (434 at defaults): clock cycles per bit.
  - Integer division.
  - M/2 means floor(M/2) = 217.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high. This is the already-decided clocking/reset convention: one clock, async active-high reset.
- `dado_serial`  in  1  serial line; idle high, LSB first.
- `recebe`  in  1  consumer acknowledge; clears `tem_dado`.
- `dados_ascii`  out  8  last received character.
- `pronto`  out  1  one-cycle pulse when a character is stored.
- `tem_dado`  out  1  level; an unread character is held.
- `erro_quadro`  out  1  one-cycle pulse when the stop bit is sampled low.
- `erro_paridade`  out  1  one-cycle pulse on parity mismatch (see Configuration).
- `db_tick`  out  1  high for the cycle in which a bit is sampled.
- `db_estado`  out  4  current FSM state code.

## Operation
- Input synchronizer:
  - `dado_serial` passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic below uses the synchronized value `s`.
- Bit-timing counter: ≥9 bits wide; cleared on every state entry.
- Shift register: shifts right, with the new bit entering at bit 7.
- FSM states (`db_estado` code):
  - INICIAL (0): wait for `s`=0, then go to START.
  - START (1):
    - Count M/2 cycles, then sample `s`.
    - If `s`=0, go to DADOS with bit index 0.
    - If `s`=1 (glitch), return to INICIAL; no flag is raised.
  - DADOS (2):
    - Count M cycles, sample `s` into the shift register, increment the bit index.
    - After the 8th sample, go to PARIDADE when enabled, otherwise to STOP.
  - PARIDADE (5): count M cycles, sample `s`, compare against the expected parity, then go to STOP.
  - STOP (3):
    - Count M cycles, then sample `s`.
    - If `s`=1, go to ARMAZENA.
    - If `s`=0, pulse `erro_quadro` and go to ESPERA.
  - ARMAZENA (4):
    - One cycle.
    - Load `dados_ascii` from the shift register, pulse `pronto`, set `tem_dado`.
    - Go to INICIAL.
  - ESPERA (6): wait for `s`=1 (line returns idle), then go to INICIAL. This prevents a break condition from being taken as a start bit.
- `db_tick` is 1 exactly in each cycle in which a START, DADOS, PARIDADE or STOP sample is taken.
- `tem_dado`:
  - Cleared on any cycle with `recebe`=1.
  - If `recebe` and ARMAZENA coincide, the set wins (`tem_dado`=1).
- Overrun:
  - A new character overwrites `dados_ascii` even if `tem_dado`=1.
  - `tem_dado` stays 1 and no error is flagged.
- A framing error does not update `dados_ascii` or `tem_dado`.

## Timing
- Reset values:
  - Synchronizer flops = 1; state = INICIAL.
  - `dados_ascii` = 0x00.
  - `pronto`, `tem_dado`, `erro_quadro`, `erro_paridade`, `db_tick` = 0.
  - `db_estado` = 0.
- Reset asserted mid-frame aborts immediately. After release, the FSM is in INICIAL and waits for a fresh falling edge.
- Let t0 be the first clock edge where `s`=0 in INICIAL (two cycles after the line falls):
  - Start sample: t0 + 1 + M/2.
  - Data bit k: t0 + 1 + M/2 + (k+1)·M.
  - Stop sample: t0 + 1 + M/2 + 9M. Add M if parity is enabled.
  - `pronto` is high during the cycle after the stop sample.
- Back-to-back frames are supported:
  - INICIAL is re-entered within 2 cycles of the stop sample.
  - This is well before the next start edge.
- `recebe` is level-sensitive and has no minimum width.

## Configuration
- Macro `RX_SERIAL_PARIDADE_EN`.
- Defined:
  - Frame is 8E1: an even-parity bit follows the data.
  - State PARIDADE is present.
  - A mismatch pulses `erro_paridade` in the stop-sample cycle.
  - The character is still stored if the stop bit is good.
- Undefined:
  - Frame is 8N1; PARIDADE is not built.
  - `erro_paridade` is tied to 0.

## Test plan
All scenarios use defaults (M=434) and the macro undefined unless stated.

1. Send 0xB5 as 8N1 -> `pronto` pulses once, `dados_ascii`=0xB5, `tem_dado`=1; after `recebe`=1 for 1 cycle, `tem_dado`=0.
2. Send 0xD5 then 0xFE back-to-back with no idle gap, `recebe` never asserted -> two `pronto` pulses, final `dados_ascii`=0xFE, `tem_dado`=1, `erro_quadro` never high.
3. Drive a 100-cycle low glitch on an idle line -> FSM returns to INICIAL, no `pronto`, no `erro_quadro`.
4. Send 0xFF with the stop bit forced low, line held low for 2M more cycles -> `erro_quadro` pulses once, FSM holds in ESPERA until the line goes high, `dados_ascii` unchanged.
5. Assert `reset` during data bit 4 of a 0x35 frame, then send 0x41 -> all outputs return to reset values; only 0x41 is received.
6. With `RX_SERIAL_PARIDADE_EN`:
   - Send 0x03 with parity bit 0 -> `pronto`, `erro_paridade`=0.
   - Send 0x03 with parity bit 1 -> `pronto` plus a one-cycle `erro_paridade` pulse.
